// File: rtl/multicycle_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_ctrl_fsm
//  Description : Multicycle control sequencer for a MIPS-subset core that
//                shares one ALU and one memory port across IF/ID/EXE/MEM/WB.
//                Decodes op/func from the IR and drives per-state datapath
//                strobes. Memory accesses use a req/ack handshake with an
//                optional timeout that raises bus_err.
//  Ports       : clk, rst (sync, active high)
//                op[5:0], func[5:0], zero, mem_ack           -> inputs
//                mem_req, mem_we, iord, ir_we, pc_we,
//                pcsource[1:0], aluc[3:0], shift, alumm, sext,
//                regrt, jal, mtoreg, wreg, state[2:0],
//                illegal, bus_err                            -> outputs
//  ALU codes   : NOP=0 ADD=1 SUB=2 AND=3 OR=4 XOR=5 NOR=6 SLT=7 SLTU=8
//                SLL=9 SRL=10 SRA=11 LUI=12
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl_fsm #(
   parameter int MEM_TIMEOUT = 16   // 0 = never time out
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] op,
   input  logic [5:0] func,
   input  logic       zero,
   input  logic       mem_ack,
   output logic       mem_req,
   output logic       mem_we,
   output logic       iord,
   output logic       ir_we,
   output logic       pc_we,
   output logic [1:0] pcsource,
   output logic [3:0] aluc,
   output logic       shift,
   output logic       alumm,
   output logic       sext,
   output logic       regrt,
   output logic       jal,
   output logic       mtoreg,
   output logic       wreg,
   output logic [2:0] state,
   output logic       illegal,
   output logic       bus_err
);

   localparam logic [3:0] C_ALUC_NOP = 4'd0,  C_ALUC_ADD = 4'd1,  C_ALUC_SUB  = 4'd2;
   localparam logic [3:0] C_ALUC_AND = 4'd3,  C_ALUC_OR  = 4'd4,  C_ALUC_XOR  = 4'd5;
   localparam logic [3:0] C_ALUC_NOR = 4'd6,  C_ALUC_SLT = 4'd7,  C_ALUC_SLTU = 4'd8;
   localparam logic [3:0] C_ALUC_SLL = 4'd9,  C_ALUC_SRL = 4'd10, C_ALUC_SRA  = 4'd11;
   localparam logic [3:0] C_ALUC_LUI = 4'd12;

   localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] C_CNT_LAST = (MEM_TIMEOUT == 0) ? '0 : CNT_W'(MEM_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IF  = 3'd0,
      S_ID  = 3'd1,
      S_EXE = 3'd2,
      S_MEM = 3'd3,
      S_WB  = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

   // Instruction decode (independent of state)
   logic       dec_legal, dec_shift, dec_alumm, dec_sext, dec_regrt;
   logic       dec_lw, dec_sw, dec_beq, dec_bne, dec_j, dec_jal, dec_jr;
   logic [3:0] dec_aluc;
   logic       timeout;

   always_comb begin
      dec_legal = 1'b1;
      dec_aluc  = C_ALUC_NOP;
      dec_shift = 1'b0;
      dec_alumm = 1'b0;
      dec_sext  = 1'b0;
      dec_regrt = 1'b0;
      dec_lw    = 1'b0;
      dec_sw    = 1'b0;
      dec_beq   = 1'b0;
      dec_bne   = 1'b0;
      dec_j     = 1'b0;
      dec_jal   = 1'b0;
      dec_jr    = 1'b0;
      case (op)
         6'b000000: begin
            case (func)
               6'b100000, 6'b100001: dec_aluc = C_ALUC_ADD;
               6'b100010, 6'b100011: dec_aluc = C_ALUC_SUB;
               6'b100100: dec_aluc = C_ALUC_AND;
               6'b100101: dec_aluc = C_ALUC_OR;
               6'b100110: dec_aluc = C_ALUC_XOR;
               6'b100111: dec_aluc = C_ALUC_NOR;
               6'b101010: dec_aluc = C_ALUC_SLT;
               6'b101011: dec_aluc = C_ALUC_SLTU;
               6'b000000: begin dec_aluc = C_ALUC_SLL; dec_shift = 1'b1; end
               6'b000010: begin dec_aluc = C_ALUC_SRL; dec_shift = 1'b1; end
               6'b000011: begin dec_aluc = C_ALUC_SRA; dec_shift = 1'b1; end
               6'b001000: dec_jr = 1'b1;
               default:   dec_legal = 1'b0;
            endcase
         end
         6'b001000: begin dec_aluc = C_ALUC_ADD; dec_alumm = 1'b1; dec_sext = 1'b1; dec_regrt = 1'b1; end
         6'b001100: begin dec_aluc = C_ALUC_AND; dec_alumm = 1'b1; dec_regrt = 1'b1; end
         6'b001101: begin dec_aluc = C_ALUC_OR;  dec_alumm = 1'b1; dec_regrt = 1'b1; end
         6'b001110: begin dec_aluc = C_ALUC_XOR; dec_alumm = 1'b1; dec_regrt = 1'b1; end
         6'b001111: begin dec_aluc = C_ALUC_LUI; dec_alumm = 1'b1; dec_regrt = 1'b1; end
         6'b100011: begin
            dec_aluc = C_ALUC_ADD; dec_alumm = 1'b1; dec_sext = 1'b1; dec_regrt = 1'b1; dec_lw = 1'b1;
         end
         6'b101011: begin dec_aluc = C_ALUC_ADD; dec_alumm = 1'b1; dec_sext = 1'b1; dec_sw = 1'b1; end
         6'b000100: begin dec_aluc = C_ALUC_SUB; dec_sext = 1'b1; dec_beq = 1'b1; end
         6'b000101: begin dec_aluc = C_ALUC_XOR; dec_sext = 1'b1; dec_bne = 1'b1; end
         6'b000010: dec_j   = 1'b1;
         6'b000011: dec_jal = 1'b1;
         default:   dec_legal = 1'b0;
      endcase
   end

   // A wait cycle that reaches the limit without an ack aborts the access.
   assign timeout = (MEM_TIMEOUT != 0) && (wait_cnt_q == C_CNT_LAST) && !mem_ack;

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = '0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      iord       = 1'b0;
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      pcsource   = 2'b00;
      aluc       = C_ALUC_NOP;
      shift      = 1'b0;
      alumm      = 1'b0;
      sext       = 1'b0;
      regrt      = 1'b0;
      jal        = 1'b0;
      mtoreg     = 1'b0;
      wreg       = 1'b0;
      illegal    = 1'b0;
      bus_err    = 1'b0;
      state      = 3'(state_q);
      case (state_q)
         S_IF: begin
            mem_req = 1'b1;
            if (mem_ack) begin
               ir_we   = 1'b1;
               pc_we   = 1'b1;
               state_d = S_ID;
            end else if (timeout) begin
               bus_err = 1'b1;        // refetch with a cleared counter
               state_d = S_IF;
            end else begin
               wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
         end
         S_ID: begin
            state_d = S_IF;
            if (!dec_legal) begin
               illegal = 1'b1;
            end else if (dec_j || dec_jal) begin
               pc_we    = 1'b1;
               pcsource = 2'b11;
               wreg     = dec_jal;
               jal      = dec_jal;
            end else if (dec_jr) begin
               pc_we    = 1'b1;
               pcsource = 2'b10;
            end else begin
               state_d = S_EXE;
            end
         end
         S_EXE: begin
            aluc  = dec_aluc;
            shift = dec_shift;
            alumm = dec_alumm;
            sext  = dec_sext;
            if (dec_beq || dec_bne) begin
               pcsource = 2'b01;
               pc_we    = dec_beq ? zero : ~zero;
               state_d  = S_IF;
            end else if (dec_lw || dec_sw) begin
               state_d = S_MEM;
            end else begin
               state_d = S_WB;
            end
         end
         S_MEM: begin
            mem_req = 1'b1;
            iord    = 1'b1;
            if (mem_ack) begin
               mem_we  = dec_sw;
               state_d = dec_lw ? S_WB : S_IF;
            end else if (timeout) begin
               bus_err = 1'b1;        // write suppressed, access abandoned
               state_d = S_IF;
            end else begin
               mem_we     = dec_sw;
               wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
         end
         S_WB: begin
            wreg    = 1'b1;
            regrt   = dec_regrt;
            mtoreg  = dec_lw;
            state_d = S_IF;
         end
         default: state_d = S_IF;
      endcase
      if (rst) begin
         mem_req  = 1'b0;
         mem_we   = 1'b0;
         iord     = 1'b0;
         ir_we    = 1'b0;
         pc_we    = 1'b0;
         pcsource = 2'b00;
         aluc     = C_ALUC_NOP;
         shift    = 1'b0;
         alumm    = 1'b0;
         sext     = 1'b0;
         regrt    = 1'b0;
         jal      = 1'b0;
         mtoreg   = 1'b0;
         wreg     = 1'b0;
         illegal  = 1'b0;
         bus_err  = 1'b0;
         state    = 3'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IF;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

endmodule
`default_nettype wire
